// File: rtl/kestrel_ifetch_pkg.sv
// Shared types and constants for the Kestrel-2 instruction-fetch front end.
package kestrel_ifetch_pkg;

  localparam int unsigned ADR_W = 15;
  localparam int unsigned INS_W = 16;
  localparam logic [ADR_W-1:0] RESET_ADR_DEF = 15'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // One queued instruction: data word plus the word address it came from.
  typedef struct packed {
    logic [INS_W-1:0] dat;
    logic [ADR_W-1:0] adr;
  } ins_ent_t;

  localparam int unsigned ENT_W = $bits(ins_ent_t);

endpackage

// File: rtl/ins_fifo.sv
// Instruction queue with a registered head; push/pop may coincide, even when full.
module ins_fifo
  import kestrel_ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = ENT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [WIDTH-1:0]        wr_dat,
  output logic [$clog2(DEPTH):0]  count,
  output logic [WIDTH-1:0]        head,
  output logic                    head_vld
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop, load_wr;

  // The head register takes the incoming word when it becomes the oldest entry.
  always_comb begin
    do_pop  = pop & (cnt_q != '0) & ~flush;
    do_push = push & ~flush & ((cnt_q != CNT_W'(DEPTH)) | do_pop);
    rd_nxt  = rd_ptr_q + PTR_W'(1);
    cnt_d   = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    load_wr = do_push & ((cnt_q == '0) | (do_pop & (cnt_q == CNT_W'(1))));
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head     <= '0;
      head_vld <= 1'b0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_vld <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_nxt;
      cnt_q    <= cnt_d;
      head_vld <= (cnt_d != '0);
      if (load_wr)     head <= wr_dat;
      else if (do_pop) head <= mem_q[rd_nxt];
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/ins_prefetch.sv
// Kestrel-2 instruction prefetcher: Wishbone read master feeding the decoder queue.
module ins_prefetch
  import kestrel_ifetch_pkg::*;
#(
  parameter int unsigned      DEPTH     = 4,
  parameter logic [ADR_W-1:0] RESET_ADR = RESET_ADR_DEF
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_i,
  output logic [ADR_W-1:0] ins_adr_o,
  input  logic [INS_W-1:0] ins_dat_i,
  output logic             ins_cyc_o,
  output logic             ins_stb_o,
  input  logic             ins_ack_i,
  input  logic             redir_i,
  input  logic [ADR_W-1:0] redir_adr_i,
  output logic [INS_W-1:0] ir_dat_o,
  output logic [ADR_W-1:0] ir_adr_o,
  output logic             ir_vld_o,
  input  logic             ir_take_i
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  state_t           state_q, state_d;
  logic [ADR_W-1:0] ptr_q, ptr_d, adr_q, adr_d;
  logic             stb_q, stb_d;
  logic             cap_vld_q, cap_vld_d;
  ins_ent_t         cap_q, cap_d, head;
  logic [CNT_W-1:0] fifo_cnt;
  logic [OCC_W-1:0] occ_left;
  logic             ack, pop, room_idle, room_ack;

  // Occupancy counts the captured word that has not reached the queue yet.
  always_comb begin
    ack       = ins_ack_i & stb_q;
    pop       = ir_take_i & ir_vld_o & ~redir_i;
    occ_left  = OCC_W'(fifo_cnt) + OCC_W'(cap_vld_q) - OCC_W'(pop);
    room_idle = occ_left < OCC_W'(DEPTH);
    room_ack  = occ_left < OCC_W'(DEPTH - 1);
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    adr_d     = adr_q;
    stb_d     = stb_q;
    cap_vld_d = 1'b0;
    cap_d     = cap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (redir_i) begin
          ptr_d   = redir_adr_i;
          adr_d   = redir_adr_i;
          stb_d   = 1'b1;
          state_d = ST_FETCH;
        end else if (room_idle) begin
          adr_d   = ptr_q;
          stb_d   = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (redir_i) begin
          ptr_d = redir_adr_i;
          if (ack) adr_d = redir_adr_i;
          else     state_d = ST_DRAIN;
        end else if (ack) begin
          cap_vld_d = 1'b1;
          cap_d.dat = ins_dat_i;
          cap_d.adr = adr_q;
          ptr_d     = ptr_q + ADR_W'(1);
          if (room_ack) begin
            adr_d = ptr_q + ADR_W'(1);
          end else begin
            stb_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        // The stale ack is swallowed; the queue is empty, so refetch at once.
        if (redir_i) ptr_d = redir_adr_i;
        if (ack) begin
          adr_d   = redir_i ? redir_adr_i : ptr_q;
          state_d = ST_FETCH;
        end
      end
      default: begin
        stb_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q   <= ST_IDLE;
      ptr_q     <= RESET_ADR;
      adr_q     <= RESET_ADR;
      stb_q     <= 1'b0;
      cap_vld_q <= 1'b0;
      cap_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      adr_q     <= adr_d;
      stb_q     <= stb_d;
      cap_vld_q <= cap_vld_d;
      cap_q     <= cap_d;
    end
  end

  ins_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk      (sys_clk_i),
    .rst      (sys_rst_i),
    .push     (cap_vld_q),
    .pop      (pop),
    .flush    (redir_i),
    .wr_dat   (cap_q),
    .count    (fifo_cnt),
    .head     (head),
    .head_vld (ir_vld_o)
  );

  assign ins_adr_o = adr_q;
  assign ins_cyc_o = stb_q;
  assign ins_stb_o = stb_q;
  assign ir_dat_o  = head.dat;
  assign ir_adr_o  = head.adr;

endmodule

// File: tb/tb_ins_prefetch.sv
// Self-checking bench for ins_prefetch: paced memory model, queue scoreboard, directed phases.
module tb_ins_prefetch;
  import kestrel_ifetch_pkg::*;

  localparam logic [14:0] RST_ADR = 15'h0000;

  logic        sys_clk_i, sys_rst_i;
  logic [14:0] ins_adr_o;
  logic [15:0] ins_dat_i;
  logic        ins_cyc_o, ins_stb_o, ins_ack_i;
  logic        redir_i;
  logic [14:0] redir_adr_i;
  logic [15:0] ir_dat_o;
  logic [14:0] ir_adr_o;
  logic        ir_vld_o, ir_take_i;

  int n_checks = 0;
  int n_fail   = 0;
  int n_push   = 0;
  int n_take   = 0;

  ins_ent_t    sb[$];
  logic [14:0] taken_adr[$];
  ins_ent_t    exp_e, new_e;
  logic [14:0] exp_ptr;
  logic        drain, vld0_due, prev_stb, prev_ack;
  logic [14:0] prev_adr;
  int          run;

  ins_prefetch #(
    .DEPTH     (4),
    .RESET_ADR (RST_ADR)
  ) dut (
    .sys_clk_i   (sys_clk_i),
    .sys_rst_i   (sys_rst_i),
    .ins_adr_o   (ins_adr_o),
    .ins_dat_i   (ins_dat_i),
    .ins_cyc_o   (ins_cyc_o),
    .ins_stb_o   (ins_stb_o),
    .ins_ack_i   (ins_ack_i),
    .redir_i     (redir_i),
    .redir_adr_i (redir_adr_i),
    .ir_dat_o    (ir_dat_o),
    .ir_adr_o    (ir_adr_o),
    .ir_vld_o    (ir_vld_o),
    .ir_take_i   (ir_take_i)
  );

  initial begin
    sys_clk_i = 1'b0;
    forever #5 sys_clk_i = ~sys_clk_i;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk_i);
    #1;
  endtask

  // Program memory: word n = A000+n, acks the cycle after stb, never two cycles running.
  initial begin
    ins_ack_i = 1'b0;
    ins_dat_i = '0;
    run       = 0;
    forever begin
      @(negedge sys_clk_i);
      if (sys_rst_i || !ins_stb_o) begin
        ins_ack_i = 1'b0;
        run       = 0;
      end else if (ins_ack_i) begin
        ins_ack_i = 1'b0;
        run       = 1;
      end else if (run >= 1) begin
        ins_ack_i = 1'b1;
        ins_dat_i = 16'hA000 + 16'(ins_adr_o);
      end else begin
        run++;
      end
    end
  end

  // Monitor: evaluates what the coming rising edge will sample.
  initial begin
    exp_ptr  = RST_ADR;
    drain    = 1'b0;
    vld0_due = 1'b0;
    prev_stb = 1'b0;
    prev_ack = 1'b0;
    prev_adr = '0;
    forever begin
      @(negedge sys_clk_i);
      #2;
      if (sys_rst_i) begin
        sb.delete();
        exp_ptr  = RST_ADR;
        drain    = 1'b0;
        vld0_due = 1'b0;
        prev_stb = 1'b0;
      end else begin
        check("cyc_eq_stb", 32'(ins_cyc_o), 32'(ins_stb_o));
        if (vld0_due) check("vld_after_redir", 32'(ir_vld_o), 32'd0);
        if (prev_stb && !prev_ack && ins_stb_o)
          check("adr_hold", 32'(ins_adr_o), 32'(prev_adr));
        if (ir_vld_o && ir_take_i && !redir_i) begin
          check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            exp_e = sb.pop_front();
            check("ir_dat", 32'(ir_dat_o), 32'(exp_e.dat));
            check("ir_adr", 32'(ir_adr_o), 32'(exp_e.adr));
          end
          taken_adr.push_back(ir_adr_o);
          n_take++;
        end
        if (ins_stb_o && ins_ack_i) begin
          if (drain) begin
            drain = 1'b0;
          end else begin
            check("fetch_adr", 32'(ins_adr_o), 32'(exp_ptr));
            if (!redir_i) begin
              new_e.dat = 16'hA000 + 16'(exp_ptr);
              new_e.adr = exp_ptr;
              sb.push_back(new_e);
              exp_ptr = exp_ptr + 15'd1;
              n_push++;
            end
          end
        end else if (ins_stb_o && redir_i) begin
          drain = 1'b1;
        end
        if (redir_i) begin
          sb.delete();
          exp_ptr = redir_adr_i;
        end
        vld0_due = redir_i;
        prev_stb = ins_stb_o;
        prev_ack = ins_ack_i;
        prev_adr = ins_adr_o;
      end
    end
  end

  initial begin
    int k;
    int n;
    sys_rst_i   = 1'b1;
    redir_i     = 1'b0;
    redir_adr_i = '0;
    ir_take_i   = 1'b0;
    repeat (3) tick();
    check("rst_cyc", 32'(ins_cyc_o), 32'd0);
    check("rst_stb", 32'(ins_stb_o), 32'd0);
    check("rst_adr", 32'(ins_adr_o), 32'(RST_ADR));
    check("rst_vld", 32'(ir_vld_o), 32'd0);
    check("rst_ir_dat", 32'(ir_dat_o), 32'd0);
    check("rst_ir_adr", 32'(ir_adr_o), 32'd0);

    // Fill from reset with no consumer.
    sys_rst_i = 1'b0;
    k = 0;
    while (!ins_stb_o && k < 20) begin tick(); k++; end
    check("stb_rise", 32'(ins_stb_o), 32'd1);
    k = 0;
    while (!ir_vld_o && k < 20) begin tick(); k++; end
    check("first_word_latency", 32'(k), 32'd3);
    repeat (20) tick();
    check("fill_cyc", 32'(ins_cyc_o), 32'd0);
    check("fill_stb", 32'(ins_stb_o), 32'd0);
    check("fill_vld", 32'(ir_vld_o), 32'd1);
    check("fill_head_adr", 32'(ir_adr_o), 32'h0);
    check("fill_head_dat", 32'(ir_dat_o), 32'hA000);
    check("fill_count", 32'(n_push), 32'd4);

    // Drain continuously; redirect while address 5 is outstanding and unacked.
    ir_take_i = 1'b1;
    k = 0;
    while (!(ins_stb_o && ins_adr_o == 15'd5) && k < 40) begin tick(); k++; end
    check("reach_adr5", 32'(ins_adr_o), 32'd5);
    redir_i     = 1'b1;
    redir_adr_i = 15'h0100;
    tick();
    redir_i = 1'b0;
    check("drain_stb", 32'(ins_stb_o), 32'd1);
    check("drain_adr", 32'(ins_adr_o), 32'd5);
    tick();
    check("redir_fetch_adr", 32'(ins_adr_o), 32'h0100);
    k = 0;
    while (!ir_vld_o && k < 20) begin tick(); k++; end
    check("redir_first_adr", 32'(ir_adr_o), 32'h0100);
    check("redir_first_dat", 32'(ir_dat_o), 32'hA100);
    repeat (10) tick();
    n = 0;
    repeat (40) begin tick(); if (ir_vld_o) n++; end
    check("steady_rate", 32'(n), 32'd20);

    // Redirect on the same edge as an ack while the consumer is taking.
    k = 0;
    while (!(ins_ack_i && ins_stb_o && ir_vld_o) && k < 20) begin tick(); k++; end
    check("ack_with_vld", 32'(ins_ack_i && ir_vld_o), 32'd1);
    redir_i     = 1'b1;
    redir_adr_i = 15'h0040;
    tick();
    redir_i = 1'b0;
    check("redir_ack_vld", 32'(ir_vld_o), 32'd0);
    check("redir_ack_stb", 32'(ins_stb_o), 32'd1);
    check("redir_ack_adr", 32'(ins_adr_o), 32'h0040);
    k = 0;
    while (!ir_vld_o && k < 20) begin tick(); k++; end
    check("redir_ack_first_adr", 32'(ir_adr_o), 32'h0040);
    check("redir_ack_first_dat", 32'(ir_dat_o), 32'hA040);

    // Address wrap at the top of the 15-bit space.
    repeat (3) tick();
    redir_i     = 1'b1;
    redir_adr_i = 15'h7FFE;
    taken_adr.delete();
    tick();
    redir_i = 1'b0;
    k = 0;
    while (taken_adr.size() < 4 && k < 60) begin tick(); k++; end
    check("wrap_words", 32'(taken_adr.size() >= 4), 32'd1);
    if (taken_adr.size() >= 4) begin
      check("wrap_0", 32'(taken_adr[0]), 32'h7FFE);
      check("wrap_1", 32'(taken_adr[1]), 32'h7FFF);
      check("wrap_2", 32'(taken_adr[2]), 32'h0000);
      check("wrap_3", 32'(taken_adr[3]), 32'h0001);
    end

    // Full queue with an irregular consumer, then reset in the middle of a fetch.
    ir_take_i = 1'b0;
    repeat (15) tick();
    check("full_vld", 32'(ir_vld_o), 32'd1);
    n = n_take;
    repeat (80) begin
      ir_take_i = ($urandom_range(0, 2) != 0);
      tick();
    end
    check("random_progress", 32'(n_take > n + 10), 32'd1);
    ir_take_i = 1'b1;
    k = 0;
    while (!ins_stb_o && k < 20) begin tick(); k++; end
    check("stb_before_reset", 32'(ins_stb_o), 32'd1);
    sys_rst_i = 1'b1;
    #1;
    check("async_rst_cyc", 32'(ins_cyc_o), 32'd0);
    check("async_rst_stb", 32'(ins_stb_o), 32'd0);
    check("async_rst_vld", 32'(ir_vld_o), 32'd0);
    check("async_rst_adr", 32'(ins_adr_o), 32'(RST_ADR));
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
